// File: rtl/stopwatch_ctrl_if.sv
// stopwatch_ctrl_if: button inputs and digit-scan outputs of the stopwatch.
// master drives the buttons, slave is the controller.
interface stopwatch_ctrl_if;
  logic       btn_start;
  logic       btn_lap;
  logic       btn_clear;
  logic [3:0] digit;
  logic [1:0] digit_sel;
  logic       dp;
  logic [1:0] state;
  logic       running;

  modport master (
    output btn_start,
    output btn_lap,
    output btn_clear,
    input  digit,
    input  digit_sel,
    input  dp,
    input  state,
    input  running
  );

  modport slave (
    input  btn_start,
    input  btn_lap,
    input  btn_clear,
    output digit,
    output digit_sel,
    output dp,
    output state,
    output running
  );
endinterface

// File: rtl/stopwatch_ctrl.sv
// stopwatch_ctrl: run/pause/lap/clear stopwatch, BCD count, digit scan.
// Minutes digit is built only when STOPWATCH_MINUTES_EN is defined.
module stopwatch_ctrl #(
  parameter logic [23:0] TICK_COUNT = 24'd1_000_000,
  parameter logic [15:0] SCAN_DIV   = 16'd50_000
) (
  input  logic             clk,
  input  logic             reset,
  stopwatch_ctrl_if.slave  bus
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    PAUSE = 2'd2,
    LAP   = 2'd3
  } state_t;

`ifdef STOPWATCH_MINUTES_EN
  localparam int         ND       = 4;
  localparam logic [1:0] SEL_LAST = 2'd3;
`else
  localparam int         ND       = 3;
  localparam logic [1:0] SEL_LAST = 2'd2;
`endif

  logic [2:0]  r_s_start;
  logic [2:0]  r_s_lap;
  logic [2:0]  r_s_clear;
  state_t      r_state;
  state_t      w_state_n;
  logic [23:0] r_pre;
  logic [3:0]  r_tenths;
  logic [3:0]  r_sec_u;
  logic [3:0]  r_sec_t;
`ifdef STOPWATCH_MINUTES_EN
  logic [3:0]  r_min;
  logic [3:0]  w_min_n;
`endif
  logic [3:0]  w_min;
  logic [3:0]  w_tenths_n;
  logic [3:0]  w_sec_u_n;
  logic [3:0]  w_sec_t_n;
  logic [4*ND-1:0] r_lap;
  logic [4*ND-1:0] w_live_n;
  logic [15:0] w_live;
  logic [15:0] w_src;
  logic [15:0] r_scan_cnt;
  logic [1:0]  r_sel;
  logic [3:0]  w_digit;
  logic        w_raw_st;
  logic        w_raw_lp;
  logic        w_ev_cl;
  logic        w_ev_st;
  logic        w_ev_lp;
  logic        w_snap;
  logic        w_zero;
  logic        w_run;
  logic        w_tick;

  // Synchronize buttons and keep a delayed copy for edge detect
  always_ff @(posedge clk) begin
    if (reset) begin
      r_s_start <= 3'd0;
      r_s_lap   <= 3'd0;
      r_s_clear <= 3'd0;
    end else begin
      r_s_start <= {r_s_start[1:0], bus.btn_start};
      r_s_lap   <= {r_s_lap[1:0], bus.btn_lap};
      r_s_clear <= {r_s_clear[1:0], bus.btn_clear};
    end
  end

  assign w_raw_st = r_s_start[1] & ~r_s_start[2];
  assign w_raw_lp = r_s_lap[1] & ~r_s_lap[2];
  assign w_ev_cl  = r_s_clear[1] & ~r_s_clear[2];
  assign w_ev_st  = w_raw_st & ~w_ev_cl;
  assign w_ev_lp  = w_raw_lp & ~w_ev_cl & ~w_raw_st;

  // FSM state register
  always_ff @(posedge clk) begin
    if (reset) r_state <= IDLE;
    else       r_state <= w_state_n;
  end

  // FSM next state, lap snapshot and clear strobes
  always_comb begin
    w_state_n = r_state;
    w_snap    = 1'b0;
    w_zero    = 1'b0;
    unique case (r_state)
      IDLE: begin
        if (w_ev_st) w_state_n = RUN;
      end
      RUN: begin
        if (w_ev_st) begin
          w_state_n = PAUSE;
        end else if (w_ev_lp) begin
          w_state_n = LAP;
          w_snap    = 1'b1;
        end
      end
      LAP: begin
        if (w_ev_lp)      w_state_n = RUN;
        else if (w_ev_st) w_state_n = PAUSE;
      end
      PAUSE: begin
        if (w_ev_cl) begin
          w_state_n = IDLE;
          w_zero    = 1'b1;
        end else if (w_ev_st) begin
          w_state_n = RUN;
        end
      end
      default: w_state_n = IDLE;
    endcase
  end

  assign w_run  = (r_state == RUN) || (r_state == LAP);
  assign w_tick = w_run && (r_pre == TICK_COUNT - 24'd1);

  // Prescaler: advances while counting, holds in pause
  always_ff @(posedge clk) begin
    if (reset)       r_pre <= 24'd0;
    else if (w_zero) r_pre <= 24'd0;
    else if (w_tick) r_pre <= 24'd0;
    else if (w_run)  r_pre <= r_pre + 24'd1;
  end

`ifdef STOPWATCH_MINUTES_EN
  assign w_min = r_min;
`else
  assign w_min = 4'd0;
`endif

  // BCD ripple of the time digits on each tick
  always_comb begin
    w_tenths_n = r_tenths;
    w_sec_u_n  = r_sec_u;
    w_sec_t_n  = r_sec_t;
`ifdef STOPWATCH_MINUTES_EN
    w_min_n    = r_min;
`endif
    if (w_tick) begin
      if (r_tenths != 4'd9) begin
        w_tenths_n = r_tenths + 4'd1;
      end else begin
        w_tenths_n = 4'd0;
        if (r_sec_u != 4'd9) begin
          w_sec_u_n = r_sec_u + 4'd1;
        end else begin
          w_sec_u_n = 4'd0;
          if (r_sec_t != 4'd5) begin
            w_sec_t_n = r_sec_t + 4'd1;
          end else begin
            w_sec_t_n = 4'd0;
`ifdef STOPWATCH_MINUTES_EN
            if (r_min != 4'd9) w_min_n = r_min + 4'd1;
            else               w_min_n = 4'd0;
`endif
          end
        end
      end
    end
  end

`ifdef STOPWATCH_MINUTES_EN
  assign w_live_n = {w_min_n, w_sec_t_n, w_sec_u_n, w_tenths_n};
`else
  assign w_live_n = {w_sec_t_n, w_sec_u_n, w_tenths_n};
`endif

  assign w_live = {w_min, r_sec_t, r_sec_u, r_tenths};

  // Time digit registers
  always_ff @(posedge clk) begin
    if (reset || w_zero) begin
      r_tenths <= 4'd0;
      r_sec_u  <= 4'd0;
      r_sec_t  <= 4'd0;
    end else begin
      r_tenths <= w_tenths_n;
      r_sec_u  <= w_sec_u_n;
      r_sec_t  <= w_sec_t_n;
    end
  end

`ifdef STOPWATCH_MINUTES_EN
  // Minutes digit register
  always_ff @(posedge clk) begin
    if (reset || w_zero) r_min <= 4'd0;
    else                 r_min <= w_min_n;
  end
`endif

  // Lap register takes the post-update count on lap entry
  always_ff @(posedge clk) begin
    if (reset || w_zero) r_lap <= '0;
    else if (w_snap)     r_lap <= w_live_n;
  end

  // Digit scan, free running in every state
  always_ff @(posedge clk) begin
    if (reset) begin
      r_scan_cnt <= 16'd0;
      r_sel      <= 2'd0;
    end else if (r_scan_cnt == SCAN_DIV - 16'd1) begin
      r_scan_cnt <= 16'd0;
      r_sel      <= (r_sel == SEL_LAST) ? 2'd0 : r_sel + 2'd1;
    end else begin
      r_scan_cnt <= r_scan_cnt + 16'd1;
    end
  end

  assign w_src = (r_state == LAP) ? 16'(r_lap) : w_live;

  // Select the BCD nibble for the current scan position
  always_comb begin
    w_digit = 4'd0;
    case (r_sel)
      2'd0:    w_digit = w_src[3:0];
      2'd1:    w_digit = w_src[7:4];
      2'd2:    w_digit = w_src[11:8];
      default: w_digit = w_src[15:12];
    endcase
  end

  assign bus.digit     = w_digit;
  assign bus.digit_sel = r_sel;
  assign bus.dp        = (r_sel == 2'd1);
  assign bus.state     = r_state;
  assign bus.running   = w_run;

endmodule

// File: tb/tb_stopwatch_ctrl.sv
// tb_stopwatch_ctrl: directed checks of stopwatch_ctrl.
// TICK_COUNT=4, SCAN_DIV=2; follows STOPWATCH_MINUTES_EN.
module tb_stopwatch_ctrl;
  logic clk = 1'b0;
  logic reset;
  int   checks = 0;
  int   errors = 0;
  logic [3:0] cap [4];
  int   seen3;
  int   dp_bad;

`ifdef STOPWATCH_MINUTES_EN
  localparam int ND = 4;
`else
  localparam int ND = 3;
`endif

  stopwatch_ctrl_if sif ();

  stopwatch_ctrl #(
    .TICK_COUNT (24'd4),
    .SCAN_DIV   (16'd2)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (sif)
  );

  always #5 clk = ~clk;

  task automatic cyc(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag,
                     input logic [31:0] obs,
                     input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h",
             tag, obs, exp);
    end
  endtask

  function automatic logic [15:0] live();
`ifdef STOPWATCH_MINUTES_EN
    return {dut.r_min, dut.r_sec_t,
            dut.r_sec_u, dut.r_tenths};
`else
    return {4'd0, dut.r_sec_t,
            dut.r_sec_u, dut.r_tenths};
`endif
  endfunction

  task automatic do_reset();
    sif.btn_start = 1'b0;
    sif.btn_lap   = 1'b0;
    sif.btn_clear = 1'b0;
    reset = 1'b1;
    cyc(2);
    reset = 1'b0;
  endtask

  // 0 start, 1 lap, 2 clear, 3 start+clear; 3 cycles total
  task automatic pulse(input int which);
    sif.btn_start = (which == 0) || (which == 3);
    sif.btn_lap   = (which == 1);
    sif.btn_clear = (which == 2) || (which == 3);
    cyc(1);
    sif.btn_start = 1'b0;
    sif.btn_lap   = 1'b0;
    sif.btn_clear = 1'b0;
    cyc(2);
  endtask

  // 16 cycles of scan, recording digit per position
  task automatic scan_cap();
    for (int i = 0; i < 4; i++) cap[i] = 4'hF;
    seen3  = 0;
    dp_bad = 0;
    repeat (16) begin
      cap[sif.digit_sel] = sif.digit;
      if (sif.digit_sel == 2'd3) seen3++;
      if (sif.dp !== (sif.digit_sel == 2'd1)) dp_bad++;
      cyc(1);
    end
  endtask

  initial begin
    do_reset();
    chk("rst_state", sif.state, 0);
    chk("rst_sel", sif.digit_sel, 0);
    chk("rst_digit", sif.digit, 0);
    chk("rst_dp", sif.dp, 0);
    chk("rst_running", sif.running, 0);
    chk("rst_live", live(), 0);

    sif.btn_start = 1'b1;
    cyc(1);
    cyc(1);
    chk("start_lat_n1", sif.state, 0);
    cyc(1);
    chk("start_lat_n2", sif.state, 1);
    chk("running_run", sif.running, 1);
    sif.btn_start = 1'b0;
    cyc(40);
    chk("run_40", live(), 16'h0010);
    chk("held_one_event", sif.state, 1);
    scan_cap();
    chk("dp_only_sel1", dp_bad, 0);

    do_reset();
    pulse(0);
    cyc(25);
    pulse(1);
    chk("lap_state", sif.state, 3);
    chk("lap_live", live(), 16'h0007);
    chk("lap_reg", 32'(dut.r_lap), 32'h7);
    scan_cap();
    chk("lap_d0", cap[0], 4'h7);
    chk("lap_d1", cap[1], 4'h0);
    chk("lap_d2", cap[2], 4'h0);
    chk("lap_d3", cap[3], (ND == 4) ? 4'h0 : 4'hF);
    chk("lap_live_adv", live(), 16'h0011);
    pulse(1);
    chk("unlap_state", sif.state, 1);
    pulse(0);
    chk("pause_state", sif.state, 2);
    chk("pause_live", live(), 16'h0012);
    chk("pause_pre", dut.r_pre, 2);
    scan_cap();
    chk("live_d0", cap[0], 4'h2);
    chk("live_d1", cap[1], 4'h1);
    chk("pause_hold", live(), 16'h0012);

    sif.btn_start = 1'b1;
    cyc(1);
    sif.btn_start = 1'b0;
    cyc(2);
    chk("resume_state", sif.state, 1);
    chk("resume_pre", dut.r_pre, 2);
    cyc(1);
    chk("resume_r1", live(), 16'h0012);
    cyc(1);
    chk("resume_r2", live(), 16'h0013);

    pulse(2);
    chk("clr_run_state", sif.state, 1);
    chk("clr_run_live", live(), 16'h0013);
    pulse(0);
    chk("pause2_state", sif.state, 2);
    chk("pause2_live", live(), 16'h0014);
    pulse(3);
    chk("clr_state", sif.state, 0);
    chk("clr_live", live(), 16'h0000);
    chk("clr_pre", dut.r_pre, 0);
    chk("clr_running", sif.running, 0);
    scan_cap();
    chk("clr_d0", cap[0], 4'h0);
    chk("clr_d1", cap[1], 4'h0);
    chk("clr_d2", cap[2], 4'h0);

    do_reset();
    pulse(0);
    if (ND == 4) begin
      cyc(23996);
      chk("pre_wrap", live(), 16'h9599);
    end else begin
      cyc(2396);
      chk("pre_wrap", live(), 16'h0599);
    end
    cyc(4);
    chk("wrap_live", live(), 16'h0000);
    chk("wrap_state", sif.state, 1);
    scan_cap();
    chk("sel3_seen", seen3 > 0, ND == 4);

    do_reset();
    pulse(0);
    cyc(136);
    chk("pre_reset_live", live(), 16'h0034);
    reset = 1'b1;
    sif.btn_start = 1'b1;
    cyc(1);
    chk("mid_rst_state", sif.state, 0);
    chk("mid_rst_live", live(), 0);
    chk("mid_rst_sel", sif.digit_sel, 0);
    chk("mid_rst_digit", sif.digit, 0);
    chk("mid_rst_running", sif.running, 0);
    reset = 1'b0;
    sif.btn_start = 1'b0;
    cyc(2);

    $display("Simulation finished: %0d checks, %0d errors",
             checks, errors);
    $finish;
  end
endmodule

// File: doc/stopwatch_ctrl.md
# stopwatch_ctrl

- Stopwatch controller that sequences the single-digit seven-segment datapath.
- Turns three push-button inputs into run/pause/lap/clear control and keeps a BCD elapsed-time count in 0.1 s steps.
- Time-multiplexes the digits onto one BCD output that feeds the existing `seg7` decoder.
- Sits between the top-level `ui_in` buttons and `seg7`; `digit_sel` drives `uio_out` so external logic can latch or identify the digit being shown.

## Interface

Parameters:
- `TICK_COUNT`, default `24'd1_000_000`: clk cycles per 0.1 s tick (10 MHz clock).
- `SCAN_DIV`, default `16'd50_000`: clk cycles each digit is presented before the scan advances.

Ports:
- `clk`  in  1  clock.
- `reset`  in  1  synchronous, active-high reset.
- `btn_start`  in  1  raw asynchronous level; a rising edge toggles run/pause.
- `btn_lap`  in  1  raw asynchronous level; a rising edge toggles lap freeze.
- `btn_clear`  in  1  raw asynchronous level; a rising edge zeroes the count when paused.
- `digit`  out  4  BCD value for the currently selected digit; goes to `seg7`.
- `digit_sel`  out  2  digit index: 0 = tenths, 1 = seconds units, 2 = seconds tens, 3 = minutes.
- `dp`  out  1  decimal point; high only while `digit_sel` = 1.
- `state`  out  2  FSM state: IDLE = 0, RUN = 1, PAUSE = 2, LAP = 3.
- `running`  out  1  high when `state` is RUN or LAP.

## Operation

Button handling:
- Each button passes through a 2-flop synchronizer, then a third flop for edge detection.
- An event is a one-cycle pulse: `s2 & ~s3`.
- Priority when events coincide: clear > start > lap. The lower-priority events in that cycle are discarded.

FSM transitions (events not listed for a state are ignored):
- IDLE: start → RUN.
- RUN: start → PAUSE; lap → LAP (snapshot the live count into the lap register in the same cycle).
- LAP: lap → RUN; start → PAUSE (display returns to live).
- PAUSE: start → RUN; clear → IDLE (zero all time digits and the prescaler).

Prescaler:
- 24-bit counter, advances only in RUN and LAP.
- At `TICK_COUNT-1` it issues a one-cycle tick and returns to 0.
- In PAUSE it holds its value, so resuming continues the partial tick.

Time digits (advance on tick only):
- Tenths 0–9, carrying into seconds units 0–9.
- Seconds units carry into seconds tens 0–5.
- Seconds tens carry into minutes 0–9.
- 9:59.9 + tick → 0:00.0; the wrap is silent and the state is unchanged.

Display:
- The scan counter runs in every state.
- `digit_sel` advances every `SCAN_DIV` cycles: 0→1→2→3→0.
- The digit source is the lap register in LAP and the live count otherwise.
- `digit` and `dp` are combinational from `digit_sel` and the registers.

## Timing

Reset:
- All registers clear: `state` = IDLE, all digits 0, lap register 0, prescaler 0, scan 0.
- Outputs after reset: `digit_sel` = 0, `digit` = 0, `dp` = 0, `running` = 0.
- Reset asserted mid-count overrides every other input on that edge.

Button latency:
- A button first sampled high at clk edge N gives `state` updated at edge N+2.
- Pulses shorter than one clk period may be missed; buttons are not debounced.
- Holding a button produces exactly one event.

Tick timing:
- The first tick after IDLE → RUN occurs `TICK_COUNT` cycles after the transition edge.
- Tenths updates on the edge following the tick pulse.

Snapshot:
- The lap snapshot captures the count including any digit update made on the same edge.

Scan:
- `digit_sel` holds for exactly `SCAN_DIV` cycles per position.
- Scan timing is independent of the FSM state.

## Configuration

`STOPWATCH_MINUTES_EN`:
- Defined: four digits as above; scan cycles through 0–3; wrap occurs at 9:59.9.
- Undefined:
  - the minutes register is not built;
  - scan cycles through 0–2 (2 → 0);
  - the count wraps 59.9 → 00.0;
  - `digit` never presents index 3.

## Test plan

Unless noted: `TICK_COUNT` = 4, `SCAN_DIV` = 2, `STOPWATCH_MINUTES_EN` defined.

- Reset, then pulse `btn_start` high for 3 cycles → `state` = 1 two edges after it is sampled; after 40 cycles the live count = 0:01.0; `dp` high only while `digit_sel` = 1.
- RUN at 0:00.7, pulse `btn_lap` → `state` = 3; `digit` shows 7 at `digit_sel` 0 while the live count keeps advancing; pulse `btn_lap` again → live value shown.
- RUN, pulse `btn_start` 2 cycles into a tick → PAUSE with count held; resume → next tick arrives 2 cycles after the RUN edge.
- In RUN, pulse `btn_clear` → ignored. In PAUSE, raise `btn_clear` and `btn_start` together → IDLE with all digits 0 (clear wins).
- Preload to 9:59.9 via run time, then one tick → 0:00.0 with `state` still RUN. With `STOPWATCH_MINUTES_EN` undefined, 59.9 → 00.0 and `digit_sel` never equals 3.
- Assert `reset` during RUN at 0:03.4 → next edge gives `state` = 0, all digits 0, `digit_sel` = 0.
